alu_result_stage: RTL and testbench

//  Registered output stage directly downstream of the n-bit combinational ALU.
//  - Captures {carry, Y, mode} from the ALU under a valid/ready handshake.
//  - Derives status flags and holds results in a 2-entry skid buffer, giving full throughput.
//  - Counts delivered results for the consumer (register file / display stage).

---
 rtl/alu_result_stage_if.sv | 41 ++++
 rtl/alu_result_stage.sv | 161 ++++++++++++++++
 tb/tb_alu_result_stage.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, the result stage and its consumer.
// out_par is present only when ALU_RES_PARITY_EN is defined.
interface alu_result_stage_if #(
  parameter int N = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_y;
  logic         in_carry;
  logic [2:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_y;
  logic         out_carry;
  logic         out_zero;
  logic         out_neg;
  logic [2:0]   out_mode;
`ifdef ALU_RES_PARITY_EN
  logic         out_par;
`endif

  // Environment side: drives the ALU result and the consumer ready.
  modport master (
    output in_valid, in_y, in_carry, in_mode, out_ready,
    input  in_ready, out_valid, out_y, out_carry, out_zero, out_neg,
`ifdef ALU_RES_PARITY_EN
    input  out_par,
`endif
    input  out_mode
  );

  // Result stage side.
  modport slave (
    input  in_valid, in_y, in_carry, in_mode, out_ready,
    output in_ready, out_valid, out_y, out_carry, out_zero, out_neg,
`ifdef ALU_RES_PARITY_EN
    output out_par,
`endif
    output out_mode
  );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: 2-entry skid buffer, capture-time flags, saturating delivery counter.
// Optional even-parity flag out_par is enabled by defining ALU_RES_PARITY_EN.
module alu_result_stage #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_result_stage_if.slave    bus,
  input  logic                 count_clr,
  output logic [CNT_W-1:0]     res_count
);

  typedef struct packed {
    logic [N-1:0] y;
    logic         carry;
    logic [2:0]   mode;
    logic         zero;
    logic         neg;
`ifdef ALU_RES_PARITY_EN
    logic         par;
`endif
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam int         ENTRY_W   = $bits(entry_t);
  localparam entry_t     ENTRY_RST = entry_t'({ENTRY_W{1'b0}});
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

`ifdef ALU_RES_PARITY_EN
  function automatic logic even_parity(input logic [N-1:0] v);
    return ^v;
  endfunction
`endif

  // Flags are fixed here, at capture, and travel with the entry afterwards.
  function automatic entry_t capture(input logic [N-1:0] y,
                                     input logic         carry,
                                     input logic [2:0]   mode);
    entry_t e;
    e.y     = y;
    e.carry = carry;
    e.mode  = mode;
    e.zero  = (y == {N{1'b0}});
    e.neg   = y[N-1];
`ifdef ALU_RES_PARITY_EN
    e.par   = even_parity(y);
`endif
    return e;
  endfunction

  state_t           state_q, state_d;
  entry_t           o_q, o_d;
  entry_t           s_q, s_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_fire_s;
  logic             out_fire_s;
  entry_t           in_entry_s;

  assign in_fire_s  = bus.in_valid & in_ready_q;
  assign out_fire_s = out_valid_q & bus.out_ready;
  assign in_entry_s = capture(bus.in_y, bus.in_carry, bus.in_mode);

  // Skid-buffer occupancy FSM: routes new data to O or S and refills O from S.
  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    s_d     = s_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire_s) begin
          o_d     = in_entry_s;
          state_d = ST_ONE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        case ({in_fire_s, out_fire_s})
          2'b01: state_d = ST_EMPTY;
          2'b10: begin
            s_d     = in_entry_s;
            state_d = ST_FULL;
          end
          2'b11: begin
            o_d     = in_entry_s;
            state_d = ST_ONE;
          end
          default: state_d = ST_ONE;
        endcase
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain of S into O can happen.
        if (out_fire_s) begin
          o_d     = s_q;
          state_d = ST_ONE;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // Delivered-result counter; clear has priority over a simultaneous delivery.
  always_comb begin
    cnt_d = cnt_q;
    if (count_clr) begin
      cnt_d = CNT_ZERO;
    end else if (out_fire_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, data and handshake registers; reset discards both entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      o_q         <= ENTRY_RST;
      s_q         <= ENTRY_RST;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      o_q         <= o_d;
      s_q         <= s_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = o_q.y;
  assign bus.out_carry = o_q.carry;
  assign bus.out_mode  = o_q.mode;
  assign bus.out_zero  = o_q.zero;
  assign bus.out_neg   = o_q.neg;
`ifdef ALU_RES_PARITY_EN
  assign bus.out_par   = o_q.par;
`endif
  assign res_count     = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: driver pushes expected results, monitor pops on each out fire.
// Parity checks are active when ALU_RES_PARITY_EN is defined.
module tb_alu_result_stage;
  localparam int N     = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [N-1:0] y;
    logic         c;
    logic [2:0]   m;
    logic         z;
    logic         ng;
    logic         p;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             count_clr = 1'b0;
  logic [CNT_W-1:0] res_count;
  logic             rand_rdy = 1'b0;

  int   total = 0;
  int   passed = 0;
  int   stalls = 0;
  int   model_cnt = 0;
  exp_t sb[$];

  alu_result_stage_if #(.N(N)) bus ();

  alu_result_stage #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .count_clr (count_clr),
    .res_count (res_count)
  );

  always #5 clk = ~clk;

  // Reference: flags follow directly from the numeric value of Y.
  function automatic exp_t model(input logic [N-1:0] y, input logic c, input logic [2:0] m);
    exp_t e;
    e.y  = y;
    e.c  = c;
    e.m  = m;
    e.z  = (int'(y) == 0);
    e.ng = (int'(y) >= (1 << (N - 1)));
`ifdef ALU_RES_PARITY_EN
    e.p  = (($countones(y) % 2) == 1);
`else
    e.p  = 1'b0;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic send(input logic [N-1:0] y, input logic c, input logic [2:0] m);
    int waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_y     = y;
    bus.in_carry = c;
    bus.in_mode  = m;
    #1;
    while (bus.in_ready !== 1'b1) begin
      if (waited > 500) begin
        total++;
        $display("FAIL send_timeout: in_ready stuck at %b, required 1", bus.in_ready);
        bus.in_valid = 1'b0;
        return;
      end
      stalls++;
      waited++;
      @(negedge clk);
      #1;
    end
    sb.push_back(model(y, c, m));
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    count_clr    = 1'b0;
  endtask

  task automatic send_rand();
    send(N'($urandom), 1'($urandom), 3'($urandom));
  endtask

  always @(negedge clk) begin
    if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: compare every delivered result against the scoreboard and track the counter.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    #2;
    if (rst_n === 1'b1) begin
      chk("res_count", 32'(res_count), 32'(model_cnt));
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_output: got y=%0h, required no delivery", bus.out_y);
        end else begin
          e    = sb.pop_front();
          a.y  = bus.out_y;
          a.c  = bus.out_carry;
          a.m  = bus.out_mode;
          a.z  = bus.out_zero;
          a.ng = bus.out_neg;
`ifdef ALU_RES_PARITY_EN
          a.p  = bus.out_par;
`else
          a.p  = 1'b0;
`endif
          chk("result", 32'(a), 32'(e));
        end
      end
      if (count_clr) model_cnt = 0;
      else if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && model_cnt < CMAX) model_cnt++;
    end else begin
      model_cnt = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    bus.in_valid  = 1'b0;
    bus.in_y      = '0;
    bus.in_carry  = 1'b0;
    bus.in_mode   = 3'd0;
    bus.out_ready = 1'b1;
    #3;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_y", 32'(bus.out_y), 32'd0);
    chk("rst_res_count", 32'(res_count), 32'd0);
    #4 rst_n = 1'b1;
    #9;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // 1: zero result with carry
    send(4'h0, 1'b1, 3'b000);
    idle();
    @(negedge clk); #1;
    chk("t1_res_count", 32'(res_count), 32'd1);
    chk("t1_out_valid", 32'(bus.out_valid), 32'd0);

    // 2: back-pressure fills the skid entry
    bus.out_ready = 1'b0;
    send(4'h9, 1'b0, 3'b010);
    send(4'h3, 1'b1, 3'b101);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("t2_in_ready_low", 32'(bus.in_ready), 32'd0);
    chk("t2_hold_y", 32'(bus.out_y), 32'h9);
    chk("t2_hold_neg", 32'(bus.out_neg), 32'd1);
    bus.out_ready = 1'b1;
    @(negedge clk); #1;
    chk("t2_second_y", 32'(bus.out_y), 32'h3);
    @(negedge clk); #1;
    chk("t2_in_ready_back", 32'(bus.in_ready), 32'd1);
    chk("t2_drained", 32'(bus.out_valid), 32'd0);

    // 3: full-throughput stream of 20
    @(negedge clk); count_clr = 1'b1;
    idle();
    stalls = 0;
    repeat (20) send_rand();
    idle();
    chk("t3_no_stalls", 32'(stalls), 32'd0);
    @(negedge clk); #1;
    chk("t3_res_count", 32'(res_count), 32'd20);

    // 4: saturation and clear-over-fire priority
    repeat (260) send_rand();
    idle();
    idle();
    #1;
    chk("t4_saturated", 32'(res_count), 32'(CMAX));
    send_rand();
    @(negedge clk);
    bus.in_valid = 1'b0;
    count_clr    = 1'b1;
    @(negedge clk);
    count_clr = 1'b0;
    #1;
    chk("t4_clear_wins", 32'(res_count), 32'd0);

    // random traffic with random back-pressure
    rand_rdy = 1'b1;
    repeat (150) begin
      repeat ($urandom_range(0, 2)) idle();
      send_rand();
    end
    idle();
    rand_rdy = 1'b0;
    #1 bus.out_ready = 1'b1;
    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_random", 32'(sb.size()), 32'd0);

    // 5: reset with both entries occupied
    bus.out_ready = 1'b0;
    send(4'hA, 1'b1, 3'b011);
    send(4'h5, 1'b0, 3'b110);
    idle();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t5_out_y", 32'(bus.out_y), 32'd0);
    chk("t5_out_mode", 32'(bus.out_mode), 32'd0);
    chk("t5_res_count", 32'(res_count), 32'd0);
    sb.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk); #1;
      chk("t5_nothing_delivered", 32'(bus.out_valid), 32'd0);
    end
    chk("t5_in_ready_back", 32'(bus.in_ready), 32'd1);

`ifdef ALU_RES_PARITY_EN
    // 6: parity flag
    send(4'b0111, 1'b0, 3'b001);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("t6_par_odd", 32'(bus.out_par), 32'd1);
    send(4'b0101, 1'b0, 3'b001);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("t6_par_even", 32'(bus.out_par), 32'd0);
`endif

    idle();
    idle();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
